imuldiv_int_div_iterative: RTL and testbench

IMULDIV_INT_DIV_ITERATIVE -- requirements
Module: imuldiv_int_div_iterative

---
 rtl/imuldiv_pkg.sv | 17 +
 rtl/imuldiv_int_div_iterative_dpath.sv | 90 +++++++++
 rtl/imuldiv_int_div_iterative.sv | 80 ++++++++
 tb/tb_imuldiv_int_div_iterative.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_pkg.sv
// Shared definitions for the iterative integer multiply/divide units:
// FSM states, function encodings and datapath mux selects.
package imuldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic FN_UNSIGNED = 1'b0;
    localparam logic FN_SIGNED   = 1'b1;

    localparam logic op_load = 1'b0;
    localparam logic op_next = 1'b1;

endpackage

// File: rtl/imuldiv_int_div_iterative_dpath.sv
// Restoring-division datapath: operand magnitudes, sign bits, the
// double-width remainder register, the iteration counter and result fix-up.
module imuldiv_int_div_iterative_dpath
    import imuldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 sel,
    input  logic                 fn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 cnt_zero,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH);

    logic                 fn_q;
    logic                 sign_q;
    logic                 sign_r;
    logic                 dbz;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   rem;

    logic [WIDTH-1:0]     abs_a_in;
    logic [WIDTH-1:0]     abs_b_in;
    logic [WIDTH:0]       upper_sh;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rmd;
    logic [WIDTH-1:0]     quo_out;
    logic [WIDTH-1:0]     rmd_out;

    always_comb begin
        abs_a_in = (fn == FN_SIGNED && a[WIDTH-1]) ? -a : a;
        abs_b_in = (fn == FN_SIGNED && b[WIDTH-1]) ? -b : b;
    end

    // The bit shifted out of the top takes part in the compare, so large
    // unsigned divisors never lose the carry of the partial remainder.
    always_comb begin
        upper_sh = rem[2*WIDTH-1:WIDTH-1];
        diff     = upper_sh - {1'b0, abs_b};
        if (!diff[WIDTH]) begin
            rem_next = {diff[WIDTH-1:0], rem[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = {rem[2*WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (sel == op_load) begin
                fn_q   <= fn;
                sign_q <= (fn == FN_SIGNED) && (a[WIDTH-1] ^ b[WIDTH-1]);
                sign_r <= (fn == FN_SIGNED) && a[WIDTH-1];
                abs_a  <= abs_a_in;
                abs_b  <= abs_b_in;
                dbz    <= (b == '0);
                cnt    <= CW'(WIDTH - 1);
                rem    <= {{WIDTH{1'b0}}, abs_a_in};
            end else begin
                rem    <= rem_next;
                cnt    <= cnt - 1'b1;
            end
        end
    end

    assign cnt_zero = (cnt == '0);

    // A zero divisor reports all-ones and hands back the original dividend.
    always_comb begin
        quo = rem[WIDTH-1:0];
        rmd = rem[2*WIDTH-1:WIDTH];
        if (dbz) begin
            quo_out = '1;
            rmd_out = sign_r ? -abs_a : abs_a;
        end else begin
            quo_out = (fn_q && sign_q) ? -quo : quo;
            rmd_out = (fn_q && sign_r) ? -rmd : rmd;
        end
        result = {rmd_out, quo_out};
    end

endmodule

// File: rtl/imuldiv_int_div_iterative.sv
// Iterative restoring divider with val/rdy request and response handshakes;
// one operation in flight, WIDTH cycles of computation per operation.
module imuldiv_int_div_iterative
    import imuldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 divreq_msg_fn,
    input  logic [WIDTH-1:0]     divreq_msg_a,
    input  logic [WIDTH-1:0]     divreq_msg_b,
    input  logic                 divreq_val,
    output logic                 divreq_rdy,
    output logic [2*WIDTH-1:0]   divresp_msg_result,
    output logic                 divresp_val,
    input  logic                 divresp_rdy
);

    state_t state;
    logic   cnt_zero;
    logic   accept;
    logic   dp_en;
    logic   dp_sel;

    assign accept = (state == IDLE) && divreq_val && divreq_rdy;
    assign dp_en  = accept || (state == CALC);
    assign dp_sel = (state == IDLE) ? op_load : op_next;

    // Handshake flags are registered alongside the state so rdy/val never
    // depend combinationally on the inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            divreq_rdy  <= 1'b1;
            divresp_val <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= CALC;
                        divreq_rdy <= 1'b0;
                    end
                end
                CALC: begin
                    if (cnt_zero) begin
                        state       <= DONE;
                        divresp_val <= 1'b1;
                    end
                end
                DONE: begin
                    if (divresp_rdy) begin
                        state       <= IDLE;
                        divresp_val <= 1'b0;
                        divreq_rdy  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    divreq_rdy  <= 1'b1;
                    divresp_val <= 1'b0;
                end
            endcase
        end
    end

    imuldiv_int_div_iterative_dpath #(
        .WIDTH (WIDTH)
    ) dpath (
        .clk      (clk),
        .en       (dp_en),
        .sel      (dp_sel),
        .fn       (divreq_msg_fn),
        .a        (divreq_msg_a),
        .b        (divreq_msg_b),
        .cnt_zero (cnt_zero),
        .result   (divresp_msg_result)
    );

endmodule

// File: tb/tb_imuldiv_int_div_iterative.sv
// Self-checking bench for the iterative divider: directed corner cases,
// backpressure, mid-operation reset and randomized operands vs a reference.
module tb_imuldiv_int_div_iterative;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              divreq_msg_fn;
    logic [31:0]       divreq_msg_a;
    logic [31:0]       divreq_msg_b;
    logic              divreq_val;
    logic              divreq_rdy;
    logic [63:0]       divresp_msg_result;
    logic              divresp_val;
    logic              divresp_rdy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imuldiv_int_div_iterative #(
        .WIDTH (WIDTH)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .divreq_msg_fn      (divreq_msg_fn),
        .divreq_msg_a       (divreq_msg_a),
        .divreq_msg_b       (divreq_msg_b),
        .divreq_val         (divreq_val),
        .divreq_rdy         (divreq_rdy),
        .divresp_msg_result (divresp_msg_result),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: plain language arithmetic (truncating division, remainder
    // takes the dividend's sign), with the zero-divisor rule on top.
    function automatic logic [63:0] refDiv(input logic fn, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa;
        longint sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (fn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic waitReady(input string tag);
        int n = 0;
        while (!divreq_rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!divreq_rdy) checkOutput({tag, "_rdy_timeout"}, 64'(divreq_rdy), 64'd1);
    endtask

    task automatic waitResponse(output int n);
        n = 0;
        while (!divresp_val && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic applyStimulus(input logic fn, input logic [31:0] a,
                                 input logic [31:0] b, input string tag);
        int lat;
        waitReady(tag);
        divreq_msg_fn = fn;
        divreq_msg_a  = a;
        divreq_msg_b  = b;
        divreq_val    = 1'b1;
        @(posedge clk); #1;
        divreq_val    = 1'b0;
        divreq_msg_fn = 1'($urandom);
        divreq_msg_a  = $urandom;
        divreq_msg_b  = $urandom;
        waitResponse(lat);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(WIDTH));
        checkOutput(tag, divresp_msg_result, refDiv(fn, a, b));
        divresp_rdy = 1'b1;
        @(posedge clk); #1;
        divresp_rdy = 1'b0;
        checkOutput({tag, "_consumed"}, 64'(divresp_val), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        logic        rfn;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;

        reset         = 1'b1;
        divreq_val    = 1'b0;
        divresp_rdy   = 1'b0;
        divreq_msg_fn = 1'b0;
        divreq_msg_a  = '0;
        divreq_msg_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_rdy", 64'(divreq_rdy), 64'd1);
        checkOutput("reset_val", 64'(divresp_val), 64'd0);

        applyStimulus(1'b0, 32'd100,        32'd7,        "u_100_7");
        applyStimulus(1'b1, 32'hFFFF_FFF9,  32'd2,        "s_m7_2");
        applyStimulus(1'b1, 32'd5,          32'd0,        "s_5_0");
        applyStimulus(1'b0, 32'h8000_0000,  32'd0,        "u_big_0");
        applyStimulus(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,"s_ovf");
        applyStimulus(1'b0, 32'hFFFF_FFFF,  32'd2,        "u_max_2");
        applyStimulus(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,"u_max_maxm1");
        applyStimulus(1'b1, 32'hFFFF_FFF9,  32'd0,        "s_neg_0");

        // Backpressure with a new request waiting at the input.
        waitReady("bp");
        divreq_msg_fn = 1'b0;
        divreq_msg_a  = 32'd1000;
        divreq_msg_b  = 32'd33;
        divreq_val    = 1'b1;
        @(posedge clk); #1;
        divreq_msg_fn = 1'b1;
        divreq_msg_a  = 32'hFFFF_FF00;
        divreq_msg_b  = 32'd10;
        waitResponse(lat);
        checkOutput("bp_lat", 64'(lat), 64'(WIDTH));
        held = divresp_msg_result;
        checkOutput("bp_result", held, refDiv(1'b0, 32'd1000, 32'd33));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_hold_val", 64'(divresp_val), 64'd1);
            checkOutput("bp_hold_rdy", 64'(divreq_rdy), 64'd0);
            checkOutput("bp_hold_result", divresp_msg_result, held);
        end
        divresp_rdy = 1'b1;
        @(posedge clk); #1;
        divresp_rdy = 1'b0;
        checkOutput("bp_consume_val", 64'(divresp_val), 64'd0);
        checkOutput("bp_consume_rdy", 64'(divreq_rdy), 64'd1);
        @(posedge clk); #1;
        divreq_val = 1'b0;
        checkOutput("bp_next_accepted", 64'(divreq_rdy), 64'd0);
        waitResponse(lat);
        checkOutput("bp_next_lat", 64'(lat), 64'(WIDTH));
        checkOutput("bp_next_result", divresp_msg_result,
                    refDiv(1'b1, 32'hFFFF_FF00, 32'd10));
        divresp_rdy = 1'b1;
        @(posedge clk); #1;
        divresp_rdy = 1'b0;

        // Reset in the middle of a computation abandons it.
        waitReady("rst");
        divreq_msg_fn = 1'b0;
        divreq_msg_a  = 32'd12345;
        divreq_msg_b  = 32'd7;
        divreq_val    = 1'b1;
        @(posedge clk); #1;
        divreq_val = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rst_rdy", 64'(divreq_rdy), 64'd1);
        checkOutput("rst_val", 64'(divresp_val), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (divresp_val) checkOutput("rst_stale_val", 64'(divresp_val), 64'd0);
        end
        applyStimulus(1'b0, 32'd9, 32'd3, "rst_u_9_3");

        // Randomized operands, biased toward the interesting corners.
        for (int i = 0; i < 40; i++) begin
            rfn = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 255);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 16);
                3:       rb = 32'(-$urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            applyStimulus(rfn, ra, rb, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
